retrosoc_rst_seq: RTL and testbench

Reset sequencer placed between the FPGA clock wizard/board reset and the SoC reset pad (ext_rst_n_i_pad).
- Synchronises the asynchronous board reset into the system clock domain.
- Waits for a stable clock-wizard lock, then stretches reset.
- Releases core reset and peripheral reset in a fixed order.
- Re-enters reset on lock loss, software request or watchdog request, and records the cause.

---
 rtl/retrosoc_rst_seq.sv | 147 ++++++++++++++
 tb/tb_retrosoc_rst_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/retrosoc_rst_seq.sv
// rtl/retrosoc_rst_seq.sv - board/PLL reset sequencer with ordered core and peripheral release
module retrosoc_rst_seq #(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_STABLE  = 64,
   parameter int HOLD_CYCLES  = 1024,
   parameter int PERIPH_DELAY = 16,
   parameter int CNT_W        = 16
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       pll_locked_i,
   input  logic       sw_rst_req_i,
   input  logic       wdt_rst_req_i,
   output logic       sys_rst_n_o,
   output logic       periph_rst_n_o,
   output logic [2:0] rst_cause_o,
   output logic       rst_busy_o
);

   localparam logic [1:0] S_WAIT_LOCK = 2'd0;
   localparam logic [1:0] S_HOLD      = 2'd1;
   localparam logic [1:0] S_REL_CORE  = 2'd2;
   localparam logic [1:0] S_RUN       = 2'd3;

   localparam logic [2:0] CAUSE_POR = 3'b001;
   localparam logic [2:0] CAUSE_SW  = 3'b010;
   localparam logic [2:0] CAUSE_WDT = 3'b100;

   // Terminal counts: every transition is an equality match on the count.
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);

   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   rst_int_n;
   logic                   lock_s;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       cause_q, cause_d;
   logic             sys_rst_n_q;
   logic             periph_rst_n_q;
   logic             busy_q;

   // Reset release synchroniser: cleared asynchronously, shifts in 1 on each clock.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   // Lock synchroniser: the wizard lock is asynchronous to clk_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) lock_sync_q <= '0;
      else          lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
   end

   assign rst_int_n = rst_sync_q[SYNC_STAGES-1];
   assign lock_s    = lock_sync_q[SYNC_STAGES-1];

   // Sequencer next state; held at reset values until the synchronised release.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      if (rst_int_n) begin
         case (state_q)
            S_WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == LOCK_LAST) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_HOLD: begin
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = S_REL_CORE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               // REL_CORE and RUN: re-entry priority is lock loss, then wdt, then sw.
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
                  cause_d = CAUSE_POR;
               end else if (wdt_rst_req_i) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
                  cause_d = CAUSE_WDT;
               end else if (sw_rst_req_i) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
                  cause_d = CAUSE_SW;
               end else if (state_q == S_REL_CORE) begin
                  if (cnt_q == PERIPH_LAST) begin
                     state_d = S_RUN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // State, counter and cause registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_WAIT_LOCK;
         cnt_q   <= '0;
         cause_q <= CAUSE_POR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // Outputs registered from the next state so they change on the transition edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sys_rst_n_q    <= 1'b0;
         periph_rst_n_q <= 1'b0;
         busy_q         <= 1'b1;
      end else begin
         sys_rst_n_q    <= (state_d == S_REL_CORE) || (state_d == S_RUN);
         periph_rst_n_q <= (state_d == S_RUN);
         busy_q         <= (state_d != S_RUN);
      end
   end

   assign sys_rst_n_o    = sys_rst_n_q;
   assign periph_rst_n_o = periph_rst_n_q;
   assign rst_cause_o    = cause_q;
   assign rst_busy_o     = busy_q;

endmodule

// File: tb/tb_retrosoc_rst_seq.sv
// tb/tb_retrosoc_rst_seq.sv - directed self-checking bench for retrosoc_rst_seq
module tb_retrosoc_rst_seq;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       sw_req;
   logic       wdt_req;
   logic       sys_rst_n;
   logic       periph_rst_n;
   logic [2:0] rst_cause;
   logic       rst_busy;

   int total;
   int bad;
   int n;

   localparam int LIMIT = 4000;

   retrosoc_rst_seq dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .pll_locked_i   (pll_locked),
      .sw_rst_req_i   (sw_req),
      .wdt_rst_req_i  (wdt_req),
      .sys_rst_n_o    (sys_rst_n),
      .periph_rst_n_o (periph_rst_n),
      .rst_cause_o    (rst_cause),
      .rst_busy_o     (rst_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until sys_rst_n rises; n starts at 'start'. Optionally drops raw
   // lock for one cycle and/or pulses wdt when n reaches the given values.
   task automatic run_to_sys(input int start, input int glitch_at, input int wdt_at,
                             output int cnt);
      cnt = start;
      while (!sys_rst_n && cnt < LIMIT) begin
         tick();
         cnt++;
         if (cnt == glitch_at)     pll_locked = 1'b0;
         if (cnt == glitch_at + 1) pll_locked = 1'b1;
         wdt_req = (cnt == wdt_at);
      end
      wdt_req = 1'b0;
   endtask

   task automatic run_to_periph(output int cnt);
      cnt = 0;
      while (!periph_rst_n && cnt < LIMIT) begin
         tick();
         cnt++;
      end
   endtask

   task automatic board_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      pll_locked = 1'b1;
      sw_req = 1'b0;
      wdt_req = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_sys", sys_rst_n, 0);
      check("rst_periph", periph_rst_n, 0);
      check("rst_busy", rst_busy, 1);
      check("rst_cause", rst_cause, 3'b001);

      // 1: steady lock; counts include the last edge with rst_n low (t0)
      rst_n = 1'b1;
      run_to_sys(1, -10, -10, n);
      check("s1_sys_lat", n, 2 + 64 + 1024 + 1);
      check("s1_periph_low", periph_rst_n, 0);
      check("s1_busy_hi", rst_busy, 1);
      run_to_periph(n);
      check("s1_periph_lat", n, 16);
      check("s1_busy_lo", rst_busy, 0);
      check("s1_cause", rst_cause, 3'b001);

      // 2: synced lock low exactly when the WAIT_LOCK count is 40
      board_reset();
      run_to_sys(1, 41, -10, n);
      check("s2_sys_lat", n, 2 + 64 + 1024 + 1 + 41);
      run_to_periph(n);
      check("s2_periph_lat", n, 16);

      // 3: software request in RUN
      tick();
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      check("s3_sys", sys_rst_n, 0);
      check("s3_periph", periph_rst_n, 0);
      check("s3_busy", rst_busy, 1);
      check("s3_cause", rst_cause, 3'b010);
      run_to_sys(1, -10, -10, n);
      check("s3_sys_lat", n, 1024 + 1);
      run_to_periph(n);
      check("s3_periph_lat", n, 16);

      // 4a: sw and wdt together, wdt wins
      sw_req = 1'b1;
      wdt_req = 1'b1;
      tick();
      sw_req = 1'b0;
      wdt_req = 1'b0;
      check("s4a_cause", rst_cause, 3'b100);
      check("s4a_sys", sys_rst_n, 0);
      run_to_sys(1, -10, -10, n);
      check("s4a_sys_lat", n, 1024 + 1);
      run_to_periph(n);
      check("s4a_periph_lat", n, 16);

      // 4b: synced lock loss lands on the same edge as sw+wdt, lock loss wins
      pll_locked = 1'b0;
      tick();
      tick();
      sw_req = 1'b1;
      wdt_req = 1'b1;
      tick();
      sw_req = 1'b0;
      wdt_req = 1'b0;
      check("s4b_cause", rst_cause, 3'b001);
      check("s4b_sys", sys_rst_n, 0);
      check("s4b_busy", rst_busy, 1);
      pll_locked = 1'b1;
      run_to_sys(0, -10, -10, n);
      check("s4b_relock_lat", n, 2 + 64 + 1024);

      // 5: wdt during REL_CORE
      tick();
      tick();
      check("s5_periph_pre", periph_rst_n, 0);
      wdt_req = 1'b1;
      tick();
      wdt_req = 1'b0;
      check("s5_sys", sys_rst_n, 0);
      check("s5_periph", periph_rst_n, 0);
      check("s5_cause", rst_cause, 3'b100);

      // 6: asynchronous board reset mid-HOLD
      for (int i = 0; i < 100; i++) tick();
      check("s6_cause_pre", rst_cause, 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_sys", sys_rst_n, 0);
      check("s6_periph", periph_rst_n, 0);
      check("s6_busy", rst_busy, 1);
      check("s6_cause", rst_cause, 3'b001);
      tick();
      tick();
      rst_n = 1'b1;
      run_to_sys(1, -10, 11, n);
      check("s6_wdt_ignored_lat", n, 2 + 64 + 1024 + 1);
      check("s6_cause_post", rst_cause, 3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
